// File: rtl/note_scorer_pkg.sv
// note_scorer_pkg: shared constants and state encodings for the note scorer.
//   NOTE_REST         note code meaning "no note this beat"
//   SCORE_MAX         saturation ceiling of the binary score (4 BCD digits)
//   STREAK_X2/X4      streak thresholds for the optional hit multiplier
//   judge_state_t     beat-judging FSM states
//   bcd_state_t       double-dabble engine states
//   streakShift()     multiplier expressed as a left-shift amount
package note_scorer_pkg;

  localparam int unsigned NOTE_REST = 0;
  localparam int unsigned SCORE_MAX = 9999;
  localparam int unsigned STREAK_X2 = 8;
  localparam int unsigned STREAK_X4 = 16;

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_ACCUM} judge_state_t;
  typedef enum logic {B_IDLE, B_SHIFT} bcd_state_t;

  // Streak value before the increment selects x1, x2 or x4.
  function automatic logic [1:0] streakShift(input logic [31:0] streakVal);
    if (streakVal >= STREAK_X4)      return 2'd2;
    else if (streakVal >= STREAK_X2) return 2'd1;
    else                             return 2'd0;
  endfunction

endpackage

// File: rtl/note_scorer_if.sv
// note_scorer_if: sequencer <-> scorer signal bundle.
//   master: sequencer side (drives songDone/addScore/changeScore and notes)
//   slave : scorer side (drives score, BCD copy, streak, totals, judgement)
interface note_scorer_if #(
  parameter int unsigned NOTE_W   = 3,
  parameter int unsigned SCORE_W  = 14,
  parameter int unsigned STREAK_W = 8
);
  logic                songDone;
  logic                addScore;
  logic                changeScore;
  logic [NOTE_W-1:0]   songNote;
  logic [NOTE_W-1:0]   playerNote;
  logic                playerValid;
  logic [SCORE_W-1:0]  score;
  logic [15:0]         scoreBcd;
  logic                bcdValid;
  logic [STREAK_W-1:0] streak;
  logic [7:0]          hitCount;
  logic [7:0]          missCount;
  logic                judgePulse;
  logic                judgeHit;

  modport master (
    output songDone, addScore, changeScore, songNote, playerNote, playerValid,
    input  score, scoreBcd, bcdValid, streak, hitCount, missCount, judgePulse, judgeHit
  );

  modport slave (
    input  songDone, addScore, changeScore, songNote, playerNote, playerValid,
    output score, scoreBcd, bcdValid, streak, hitCount, missCount, judgePulse, judgeHit
  );
endinterface

// File: rtl/score_bcd.sv
// score_bcd: iterative double-dabble binary -> 4-digit BCD converter.
//   clock, reset  system clock, synchronous active-high reset (aborts a conversion)
//   start         sampled in idle; captures bin and begins BIN_W shift steps
//   bin           binary value (<= 9999)
//   busy          high while shifting
//   done          1-cycle pulse after the final shift; bcd is valid from then on
//   bcd           four BCD digits
module score_bcd
  import note_scorer_pkg::*;
#(
  parameter int unsigned BIN_W = 14
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcd
);
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  bcd_state_t       state, nextState;
  logic [CNT_W-1:0] cnt;
  logic [BIN_W-1:0] binSh;
  logic [15:0]      bcdSh, bcdAdj;

  always_ff @(posedge clock) begin
    if (reset) state <= B_IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      B_IDLE:  if (start) nextState = B_SHIFT;
      B_SHIFT: if (cnt == CNT_W'(1)) nextState = B_IDLE;
      default: nextState = B_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == B_SHIFT);
  end

  // Add 3 to every digit >= 5 before each shift.
  always_comb begin
    bcdAdj = bcdSh;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcdSh[4*i +: 4] >= 4'd5) bcdAdj[4*i +: 4] = bcdSh[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt   <= '0;
      binSh <= '0;
      bcdSh <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == B_IDLE) begin
        if (start) begin
          cnt   <= CNT_W'(BIN_W);
          binSh <= bin;
          bcdSh <= '0;
        end
      end else begin
        {bcdSh, binSh} <= {bcdAdj, binSh} << 1;
        cnt            <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) done <= 1'b1;
      end
    end
  end

  assign bcd = bcdSh;

endmodule

// File: rtl/note_scorer.sv
// note_scorer: judges each beat against the song note and keeps the score.
//   clock, reset  system clock, synchronous active-high reset
//   noteBus       note_scorer_if.slave: sequencer controls and notes in,
//                 score / scoreBcd / bcdValid / streak / hitCount / missCount /
//                 judgePulse / judgeHit out
// judgePulse is high during S_ACCUM (2 clocks after addScore) with judgeHit
// already valid; score and counters show the new values the cycle after.
// Optional build macro STREAK_MULT_EN: hit points scaled x1/x2/x4 by streak.
module note_scorer
  import note_scorer_pkg::*;
#(
  parameter int unsigned NOTE_W   = 3,
  parameter int unsigned SCORE_W  = 14,
  parameter int unsigned HIT_PTS  = 10,
  parameter int unsigned STREAK_W = 8
) (
  input logic          clock,
  input logic          reset,
  note_scorer_if.slave noteBus
);
  judge_state_t        state, nextState;
  logic                songDonePrev, changePrev, newSong;
  logic [NOTE_W-1:0]   songNoteQ, playerNoteQ;
  logic                playerValidQ;
  logic                acceptBeat, evalHit, commit;
  logic [SCORE_W-1:0]  score, scoreHit;
  logic [SCORE_W:0]    hitPts, scoreSum;
  logic [STREAK_W-1:0] streak;
  logic [7:0]          hitCount, missCount;
  logic                judgeHit;
  logic                startConv, bcdBusy, bcdDone, bcdStale, bcdValid;
  logic [15:0]         bcdOut, scoreBcd;

  assign newSong = songDonePrev & ~noteBus.songDone;
  assign evalHit = playerValidQ && (playerNoteQ == songNoteQ);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      S_IDLE:  if (noteBus.addScore && !noteBus.songDone) nextState = S_EVAL;
      S_EVAL:  nextState = (songNoteQ == NOTE_W'(NOTE_REST)) ? S_IDLE : S_ACCUM;
      S_ACCUM: nextState = S_IDLE;
      default: nextState = S_IDLE;
    endcase
  end

  always_comb begin
    acceptBeat = (state == S_IDLE) && noteBus.addScore && !noteBus.songDone;
    commit     = (state == S_ACCUM);
  end

`ifdef STREAK_MULT_EN
  assign hitPts = (SCORE_W+1)'(HIT_PTS) << streakShift(32'(streak));
`else
  assign hitPts = (SCORE_W+1)'(HIT_PTS);
`endif

  assign scoreSum = {1'b0, score} + hitPts;
  assign scoreHit = (scoreSum > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                          : scoreSum[SCORE_W-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      songDonePrev <= 1'b0;
      songNoteQ    <= '0;
      playerNoteQ  <= '0;
      playerValidQ <= 1'b0;
      score        <= '0;
      streak       <= '0;
      hitCount     <= '0;
      missCount    <= '0;
      judgeHit     <= 1'b0;
    end else begin
      songDonePrev <= noteBus.songDone;
      if (acceptBeat) begin
        songNoteQ    <= noteBus.songNote;
        playerNoteQ  <= noteBus.playerNote;
        playerValidQ <= noteBus.playerValid;
      end
      if (newSong) begin
        score     <= '0;
        streak    <= '0;
        hitCount  <= '0;
        missCount <= '0;
        judgeHit  <= 1'b0;
      end else begin
        // Result is registered on entry to S_ACCUM so it is valid alongside judgePulse.
        if (state == S_EVAL && nextState == S_ACCUM) judgeHit <= evalHit;
        if (commit) begin
          if (judgeHit) begin
            score <= scoreHit;
            if (streak != '1)   streak   <= streak + 1'b1;
            if (hitCount != '1) hitCount <= hitCount + 1'b1;
          end else begin
            streak <= '0;
            if (missCount != '1) missCount <= missCount + 1'b1;
          end
        end
      end
    end
  end

  assign startConv = noteBus.changeScore && !changePrev && !bcdValid && !bcdBusy;

  // A score change while a conversion is in flight makes its result stale:
  // the conversion still completes, but bcdValid stays low until the next request.
  always_ff @(posedge clock) begin
    if (reset) begin
      changePrev <= 1'b0;
      scoreBcd   <= '0;
      bcdValid   <= 1'b0;
      bcdStale   <= 1'b0;
    end else begin
      changePrev <= noteBus.changeScore;
      if (bcdDone) begin
        scoreBcd <= bcdOut;
        bcdValid <= !bcdStale;
        bcdStale <= 1'b0;
      end
      if (commit || newSong) begin
        bcdValid <= 1'b0;
        if (bcdBusy || startConv) bcdStale <= 1'b1;
      end
      if (newSong) scoreBcd <= '0;
    end
  end

  score_bcd #(.BIN_W(SCORE_W)) u_bcd (
    .clock (clock),
    .reset (reset),
    .start (startConv),
    .bin   (score),
    .busy  (bcdBusy),
    .done  (bcdDone),
    .bcd   (bcdOut)
  );

  assign noteBus.score      = score;
  assign noteBus.scoreBcd   = scoreBcd;
  assign noteBus.bcdValid   = bcdValid;
  assign noteBus.streak     = streak;
  assign noteBus.hitCount   = hitCount;
  assign noteBus.missCount  = missCount;
  assign noteBus.judgePulse = commit;
  assign noteBus.judgeHit   = judgeHit;

endmodule

// File: tb/tb_note_scorer.sv
// tb_note_scorer: randomized self-checking bench for note_scorer.
// Reference model keeps the score/streak/totals as plain integers.
// Honours STREAK_MULT_EN when defined for the build.
module tb_note_scorer;
  localparam int unsigned NOTE_W   = 3;
  localparam int unsigned SCORE_W  = 14;
  localparam int unsigned HIT_PTS  = 10;
  localparam int unsigned STREAK_W = 8;

  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   sinceAdd = 100;

  int   mScore, mStreak, mHit, mMiss;
  bit   mJudgeHit, mBcdValid;

  always #5 clock = ~clock;

  note_scorer_if #(.NOTE_W(NOTE_W), .SCORE_W(SCORE_W), .STREAK_W(STREAK_W)) noteBus ();

  note_scorer #(
    .NOTE_W   (NOTE_W),
    .SCORE_W  (SCORE_W),
    .HIT_PTS  (HIT_PTS),
    .STREAK_W (STREAK_W)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .noteBus (noteBus.slave)
  );

  // Sequencer protocol: addScore pulses at least 3 cycles apart.
  always @(posedge clock) begin
    if (noteBus.addScore) begin
      assert (sinceAdd >= 3) else $error("addScore spacing violated: %0d", sinceAdd);
      sinceAdd = 1;
    end else if (sinceAdd < 100) begin
      sinceAdd = sinceAdd + 1;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic int hitPoints(input int streakBefore);
`ifdef STREAK_MULT_EN
    if (streakBefore >= 16) return HIT_PTS * 4;
    if (streakBefore >= 8)  return HIT_PTS * 2;
`endif
    return HIT_PTS;
  endfunction

  function automatic logic [15:0] toBcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic checkModel();
    checkVal("score",     noteBus.score,     mScore);
    checkVal("streak",    noteBus.streak,    mStreak);
    checkVal("hitCount",  noteBus.hitCount,  mHit);
    checkVal("missCount", noteBus.missCount, mMiss);
    checkVal("judgeHit",  noteBus.judgeHit,  mJudgeHit);
    checkVal("bcdValid",  noteBus.bcdValid,  mBcdValid);
  endtask

  // One beat: addScore pulse, judgePulse expected 2 clocks later (unless rest
  // or songDone), new totals visible the following cycle.
  task automatic beat(input int sn, input int pn, input bit pv);
    bit judged, hit;
    judged = !noteBus.songDone && sn != 0;
    hit    = pv && (pn == sn);
    noteBus.songNote    = NOTE_W'(sn);
    noteBus.playerNote  = NOTE_W'(pn);
    noteBus.playerValid = pv;
    noteBus.addScore    = 1'b1;
    tick();
    noteBus.addScore = 1'b0;
    checkVal("pulseEarly", noteBus.judgePulse, 0);
    tick();
    checkVal("judgePulse", noteBus.judgePulse, judged);
    if (judged) begin
      mJudgeHit = hit;
      mBcdValid = 1'b0;
      if (hit) begin
        mScore  = (mScore + hitPoints(mStreak) > 9999) ? 9999 : mScore + hitPoints(mStreak);
        mStreak = (mStreak < 255) ? mStreak + 1 : 255;
        mHit    = (mHit < 255) ? mHit + 1 : 255;
      end else begin
        mStreak = 0;
        mMiss   = (mMiss < 255) ? mMiss + 1 : 255;
      end
    end
    checkVal("judgeHitAtPulse", noteBus.judgeHit, mJudgeHit);
    tick();
    checkVal("pulseLate", noteBus.judgePulse, 0);
    checkModel();
  endtask

  // Full conversion: one edge registers the changeScore rise, then SCORE_W+1 cycles.
  task automatic convert();
    int n;
    n = 0;
    noteBus.changeScore = 1'b1;
    do begin
      tick();
      n++;
    end while (!noteBus.bcdValid && n < 40);
    checkVal("bcdLatency", n, SCORE_W + 2);
    mBcdValid = 1'b1;
    checkVal("scoreBcd", noteBus.scoreBcd, toBcd(mScore));
    checkVal("bcdValidSet", noteBus.bcdValid, 1);
    noteBus.changeScore = 1'b0;
    tick();
  endtask

  task automatic startSong();
    noteBus.songDone = 1'b1;
    repeat (3) tick();
    beat(3, 3, 1);  // ignored while the sequencer is idle
    noteBus.songDone = 1'b0;
    tick();
    mScore = 0; mStreak = 0; mHit = 0; mMiss = 0;
    mJudgeHit = 1'b0; mBcdValid = 1'b0;
    checkModel();
    checkVal("newSongBcd", noteBus.scoreBcd, 0);
  endtask

  initial begin
    int sn, pn, exp20, scoreBefore, guard;
    bit pv;

    reset               = 1'b1;
    noteBus.songDone    = 1'b1;
    noteBus.addScore    = 1'b0;
    noteBus.changeScore = 1'b0;
    noteBus.songNote    = '0;
    noteBus.playerNote  = '0;
    noteBus.playerValid = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkVal("rstScore",    noteBus.score,      0);
    checkVal("rstStreak",   noteBus.streak,     0);
    checkVal("rstHit",      noteBus.hitCount,   0);
    checkVal("rstMiss",     noteBus.missCount,  0);
    checkVal("rstPulse",    noteBus.judgePulse, 0);
    checkVal("rstJudgeHit", noteBus.judgeHit,   0);
    checkVal("rstBcdValid", noteBus.bcdValid,   0);
    checkVal("rstBcd",      noteBus.scoreBcd,   0);
    reset = 1'b0;
    tick();

    startSong();

    // First hit.
    beat(3, 3, 1);
    checkVal("t1Score",  noteBus.score,  10);
    checkVal("t1Streak", noteBus.streak, 1);

    // Three more hits then a wrong note.
    repeat (3) beat(3, 3, 1);
    beat(3, 5, 1);
    checkVal("t2Score",    noteBus.score,     40);
    checkVal("t2Streak",   noteBus.streak,    0);
    checkVal("t2Miss",     noteBus.missCount, 1);
    checkVal("t2JudgeHit", noteBus.judgeHit,  0);

    // Rests never judge.
    beat(0, 3, 1);
    beat(0, 0, 0);
    beat(0, 5, 1);

    // Matching note without playerValid is a miss.
    beat(4, 4, 0);

    for (int i = 0; i < 60; i++) begin
      sn = $urandom_range(0, 7);
      pv = ($urandom_range(0, 9) != 0);
      pn = $urandom_range(0, 1) ? sn : $urandom_range(0, 7);
      beat(sn, pn, pv);
    end

    convert();
    beat(2, 2, 1);  // any judgement invalidates the BCD copy

    // Judgement during a conversion: old value lands, bcdValid stays low.
    scoreBefore = mScore;
    noteBus.changeScore = 1'b1;
    repeat (4) tick();
    beat(6, 6, 1);
    repeat (20) tick();
    checkVal("staleValid", noteBus.bcdValid, 0);
    checkVal("staleBcd",   noteBus.scoreBcd, toBcd(scoreBefore));
    noteBus.changeScore = 1'b0;
    tick();
    convert();

    // 20 consecutive hits from a fresh song.
    startSong();
    for (int i = 0; i < 20; i++) begin
      sn = $urandom_range(1, 7);
      beat(sn, sn, 1);
    end
`ifdef STREAK_MULT_EN
    exp20 = 400;
`else
    exp20 = 200;
`endif
    checkVal("t4Score",  noteBus.score,  exp20);
    checkVal("t4Streak", noteBus.streak, 20);
    convert();

    // Run up to the ceiling; streak and hitCount also saturate on the way.
    guard = 0;
    while (mScore < 9999 && guard < 2000) begin
      sn = $urandom_range(1, 7);
      beat(sn, sn, 1);
      guard++;
    end
    repeat (2) beat(1, 1, 1);
    checkVal("satScore",  noteBus.score,    9999);
    checkVal("satStreak", noteBus.streak,   255);
    checkVal("satHit",    noteBus.hitCount, 255);
    convert();
    checkVal("satBcd", noteBus.scoreBcd, 16'h9999);
    beat(7, 1, 1);
    checkVal("satMissStreak", noteBus.streak,    0);
    checkVal("satMiss",       noteBus.missCount, 1);

    // Reset during a conversion aborts it.
    noteBus.changeScore = 1'b1;
    repeat (4) tick();
    noteBus.changeScore = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    mScore = 0; mStreak = 0; mHit = 0; mMiss = 0;
    mJudgeHit = 1'b0; mBcdValid = 1'b0;
    checkModel();
    repeat (20) tick();
    checkVal("abortValid", noteBus.bcdValid, 0);
    checkVal("abortBcd",   noteBus.scoreBcd, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
